// File: rtl/vpu_operand_fetch.sv
// vpu_operand_fetch: single-operand SRAM read engine.
// Takes {bank,row}+vlen, wins the bank, bursts row reads, streams rows out.
//
// Ports:
//   req_*   : operand request (valid/ready), base address and beats-1
//   sram_*  : bank ownership req/ack, row read strobe/address, returned rows
//   dout_*  : in-order row stream to the datapath (valid/ready, last)
//   busy    : engine not idle
module vpu_operand_fetch #(
  parameter int SRAM_BANK_CNT_LG2   = 3,
  parameter int SRAM_BANK_DEPTH_LG2 = 10,
  parameter int SRAM_DATA_WIDTH     = 256,
  parameter int VEC_LEN_LG2         = 5,
  parameter int FIFO_DEPTH          = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_valid,
  output logic req_ready,
  input  logic [SRAM_BANK_CNT_LG2+SRAM_BANK_DEPTH_LG2-1:0] req_raddr,
  input  logic [VEC_LEN_LG2-1:0] req_vlen,
  output logic sram_req,
  input  logic sram_ack,
  output logic [SRAM_BANK_CNT_LG2-1:0] sram_rid,
  output logic [SRAM_BANK_DEPTH_LG2-1:0] sram_addr,
  output logic sram_reb,
  output logic sram_rlast,
  input  logic [SRAM_DATA_WIDTH-1:0] sram_rdata,
  input  logic sram_rvalid,
  output logic dout_valid,
  input  logic dout_ready,
  output logic [SRAM_DATA_WIDTH-1:0] dout_data,
  output logic dout_last,
  output logic busy
);
  localparam int AW = SRAM_BANK_CNT_LG2 + SRAM_BANK_DEPTH_LG2;
  localparam int BW = VEC_LEN_LG2 + 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE, ARB, BURST, DRAIN
  } state_t;

  state_t state, state_nx;

  logic [BW-1:0] beats;
  logic [BW-1:0] issue_cnt;
  logic [BW-1:0] pop_cnt;
  logic [SRAM_BANK_DEPTH_LG2-1:0] row_ptr;
  logic [CW-1:0] out_cnt;
  logic [CW-1:0] fifo_cnt;
  logic [CW-1:0] wptr;
  logic [CW-1:0] rptr;
  logic [CW:0] credit;
  logic [CW:0] limit;
  logic [SRAM_DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic accept;
  logic issue;
  logic push;
  logic pop;
  logic last_pop;

  assign req_ready = (state == IDLE);
  assign busy = (state != IDLE);
  assign accept = req_valid && req_ready;

  assign fifo_cnt = wptr - rptr;
  assign dout_valid = (wptr != rptr);
  assign dout_data = dout_valid ? mem[rptr[PW-1:0]] : '0;
  assign dout_last = dout_valid && (pop_cnt + BW'(1) == beats);
  assign pop = dout_valid && dout_ready;
  assign last_pop = pop && dout_last;

  // Returns with nothing outstanding are dropped.
  assign push = sram_rvalid && (out_cnt != '0);

  // Rows owed a buffer slot: in flight, buffered, and the one on the
  // bus now. A pop this cycle frees a slot before the next read lands.
  assign credit = {1'b0, out_cnt} + {1'b0, fifo_cnt}
                + (CW+1)'(sram_reb);
  assign limit = (CW+1)'(FIFO_DEPTH) + (CW+1)'(pop);

  // reb is registered, so it reflects ack sampled at the previous edge.
  assign issue = (state == BURST) && sram_ack
              && (issue_cnt != beats) && (credit < limit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = ARB;
      ARB:     if (sram_ack) state_nx = BURST;
      BURST:   if (sram_reb && sram_rlast) state_nx = DRAIN;
      DRAIN:   if (last_pop) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sram_req   <= 1'b0;
      sram_reb   <= 1'b0;
      sram_rlast <= 1'b0;
      sram_rid   <= '0;
      sram_addr  <= '0;
      row_ptr    <= '0;
      beats      <= '0;
      issue_cnt  <= '0;
      pop_cnt    <= '0;
      out_cnt    <= '0;
      wptr       <= '0;
      rptr       <= '0;
    end else begin
      sram_req <= (state_nx == ARB)
               || (state_nx == BURST);
      sram_reb <= issue;
      sram_rlast <= issue
                 && (issue_cnt + BW'(1) == beats);
      out_cnt <= out_cnt + CW'(sram_reb)
               - CW'(push);
      if (push) wptr <= wptr + CW'(1);
      if (pop)  rptr <= rptr + CW'(1);
      if (accept) begin
        sram_rid  <= req_raddr[AW-1 -: SRAM_BANK_CNT_LG2];
        row_ptr   <= req_raddr[SRAM_BANK_DEPTH_LG2-1:0];
        beats     <= BW'(req_vlen) + BW'(1);
        issue_cnt <= '0;
        pop_cnt   <= '0;
      end else begin
        if (issue) begin
          sram_addr <= row_ptr;
          row_ptr   <= row_ptr + 1'b1;
          issue_cnt <= issue_cnt + BW'(1);
        end
        if (pop) pop_cnt <= pop_cnt + BW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr[PW-1:0]] <= sram_rdata;
  end

  always @(posedge clk) begin
    if (rst_n && sram_rvalid)
      assert (out_cnt != '0);
  end

endmodule

// File: tb/tb_vpu_operand_fetch.sv
// tb_vpu_operand_fetch: table vectors, directed corner sequences and
// random requests against a transaction-level model of the read engine.
module tb_vpu_operand_fetch;
  localparam int DW = 256;
  localparam int FD = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_valid = 1'b0;
  logic req_ready;
  logic [12:0] req_raddr = '0;
  logic [4:0] req_vlen = '0;
  logic sram_req;
  logic sram_ack = 1'b0;
  logic [2:0] sram_rid;
  logic [9:0] sram_addr;
  logic sram_reb;
  logic sram_rlast;
  logic [DW-1:0] sram_rdata = '0;
  logic sram_rvalid = 1'b0;
  logic dout_valid;
  logic dout_ready = 1'b0;
  logic [DW-1:0] dout_data;
  logic dout_last;
  logic busy;

  vpu_operand_fetch dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_raddr(req_raddr), .req_vlen(req_vlen),
    .sram_req(sram_req), .sram_ack(sram_ack),
    .sram_rid(sram_rid), .sram_addr(sram_addr),
    .sram_reb(sram_reb), .sram_rlast(sram_rlast),
    .sram_rdata(sram_rdata), .sram_rvalid(sram_rvalid),
    .dout_valid(dout_valid), .dout_ready(dout_ready),
    .dout_data(dout_data), .dout_last(dout_last),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int ret_lat = 1;

  // model of the current vector
  int m_active = 0;
  int m_rid = 0;
  int m_row = 0;
  int m_beats = 0;
  int reb_idx = 0;
  int pop_idx = 0;
  int first_rid = 0;
  int first_addr = 0;
  int rlast_addr = -1;
  int first_reb_cyc = 0;
  int last_reb_cyc = 0;
  int accept_cyc = 0;
  int last_pop_cyc = 0;
  int vec_done = 0;
  int ack_prev = 0;

  typedef struct {
    logic [DW-1:0] data;
    int due;
  } ret_t;
  ret_t rq[$];

  typedef struct {
    int bank, row, vlen, lat;
    int e_rid, e_first, e_last, e_rows, e_span;
  } vec_t;

  task automatic chk(input string nm, input longint got,
                     input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
  endtask

  task automatic chk_d(input string nm, input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  function automatic logic [DW-1:0] mk(input int rid, input int addr);
    logic [DW-1:0] d;
    for (int k = 0; k < 8; k++)
      d[k*32 +: 32] = 32'(rid * 65536 + addr) ^ (32'(k) * 32'h9E3779B9);
    return d;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // SRAM return model plus scoreboard, sampled mid-cycle.
  initial begin
    int ea;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        rq.delete();
        sram_rvalid = 1'b0;
        m_active = 0;
      end else begin
        sram_rvalid = 1'b0;
        if (rq.size() > 0 && rq[0].due <= cyc) begin
          sram_rvalid = 1'b1;
          sram_rdata = rq[0].data;
          void'(rq.pop_front());
        end
        if (sram_reb) begin
          ea = (m_row + reb_idx) % 1024;
          chk("reb_active", m_active, 1);
          chk("reb_rid", sram_rid, m_rid);
          chk("reb_addr", sram_addr, ea);
          chk("reb_rlast", sram_rlast, reb_idx == m_beats - 1);
          chk("reb_after_ack", ack_prev, 1);
          chk("reb_req_held", sram_req, 1);
          if (reb_idx == 0) begin
            first_reb_cyc = cyc;
            first_addr = sram_addr;
            first_rid = sram_rid;
          end
          if (sram_rlast) rlast_addr = sram_addr;
          last_reb_cyc = cyc;
          reb_idx++;
          chk("no_overflow", (reb_idx - pop_idx) <= FD, 1);
          rq.push_back('{mk(sram_rid, sram_addr), cyc + ret_lat});
        end
        if (dout_valid && dout_ready) begin
          chk("pop_active", m_active, 1);
          chk_d("dout_data", dout_data,
                mk(m_rid, (m_row + pop_idx) % 1024));
          chk("dout_last", dout_last, pop_idx == m_beats - 1);
          pop_idx++;
          if (pop_idx == m_beats) begin
            last_pop_cyc = cyc;
            vec_done++;
          end
        end
        if (req_valid && req_ready) begin
          m_rid = int'(req_raddr[12:10]);
          m_row = int'(req_raddr[9:0]);
          m_beats = int'(req_vlen) + 1;
          reb_idx = 0;
          pop_idx = 0;
          rlast_addr = -1;
          accept_cyc = cyc;
          m_active = 1;
        end
        ack_prev = sram_ack;
      end
    end
  end

  task automatic send_req(input int bank, input int row, input int vlen);
    int n;
    n = 0;
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_raddr = {3'(bank), 10'(row)};
    req_vlen = 5'(vlen);
    @(negedge clk);
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("req_accept_timeout", 0, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget,
                           input bit rnd);
    int n;
    n = 0;
    while (vec_done < target && n < budget) begin
      @(posedge clk); #1;
      if (rnd) begin
        sram_ack = ($urandom_range(0, 3) != 0);
        dout_ready = ($urandom_range(0, 2) != 0);
      end
      n++;
    end
    chk("vec_complete", vec_done >= target, 1);
  endtask

  initial begin
    vec_t tbl[5];
    int d0, n, r0;
    tbl[0] = '{2, 5, 3, 1, 2, 5, 8, 4, 3};
    tbl[1] = '{7, 1022, 3, 1, 7, 1022, 1, 4, 3};
    tbl[2] = '{0, 0, 0, 1, 0, 0, 0, 1, 0};
    tbl[3] = '{3, 1000, 31, 2, 3, 1000, 7, 32, 31};
    tbl[4] = '{5, 1023, 1, 2, 5, 1023, 0, 2, 1};

    #1;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_sram_req", sram_req, 0);
    chk("rst_reb", sram_reb, 0);
    chk("rst_rlast", sram_rlast, 0);
    chk("rst_dout_valid", dout_valid, 0);
    chk("rst_dout_last", dout_last, 0);
    chk("rst_busy", busy, 0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      ret_lat = tbl[i].lat;
      sram_ack = 1'b1;
      dout_ready = 1'b1;
      d0 = vec_done;
      send_req(tbl[i].bank, tbl[i].row, tbl[i].vlen);
      wait_done(d0 + 1, 500, 1'b0);
      chk("t_rid", first_rid, tbl[i].e_rid);
      chk("t_first_addr", first_addr, tbl[i].e_first);
      chk("t_rlast_addr", rlast_addr, tbl[i].e_last);
      chk("t_rebs", reb_idx, tbl[i].e_rows);
      chk("t_rows", pop_idx, tbl[i].e_rows);
      chk("t_span", last_reb_cyc - first_reb_cyc, tbl[i].e_span);
      chk("t_first_reb_lat", first_reb_cyc - accept_cyc, 3);
      @(negedge clk);
      chk("t_busy_fall", busy, 0);
      chk("t_ready_back", req_ready, 1);
    end

    // grant stall: no ack for 5 cycles, then a 3-cycle drop mid-burst
    ret_lat = 1;
    dout_ready = 1'b1;
    sram_ack = 1'b0;
    d0 = vec_done;
    send_req(1, 10, 5);
    chk("g_req_rise", sram_req, 1);
    repeat (5) begin
      @(negedge clk);
      chk("g_req_hold_noack", sram_req, 1);
    end
    chk("g_no_reb_before_ack", reb_idx, 0);
    @(posedge clk); #1 sram_ack = 1'b1;
    n = 0;
    while (reb_idx < 3 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1 sram_ack = 1'b0;
    r0 = reb_idx;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("g_req_hold_drop", sram_req, 1);
      if (k > 0) chk("g_reb_stall", sram_reb, 0);
    end
    chk("g_drop_rebs", reb_idx - r0 <= 1, 1);
    @(posedge clk); #1 sram_ack = 1'b1;
    wait_done(d0 + 1, 500, 1'b0);
    chk("g_rebs", reb_idx, 6);
    chk("g_rows", pop_idx, 6);
    chk("g_rlast_addr", rlast_addr, 15);

    // backpressure: consumer stalled, reads capped by buffer depth
    ret_lat = 2;
    sram_ack = 1'b1;
    dout_ready = 1'b0;
    d0 = vec_done;
    send_req(6, 200, 15);
    repeat (20) @(negedge clk);
    chk("bp_reb_cap", reb_idx, FD);
    chk("bp_no_pop", pop_idx, 0);
    chk("bp_dout_valid", dout_valid, 1);
    @(posedge clk); #1 dout_ready = 1'b1;
    wait_done(d0 + 1, 500, 1'b0);
    chk("bp_rows", pop_idx, 16);
    chk("bp_rlast_addr", rlast_addr, 215);

    // single beat, then a held request taken right after the pop
    ret_lat = 1;
    d0 = vec_done;
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_raddr = {3'd3, 10'd77};
    req_vlen = 5'd0;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    req_raddr = {3'd5, 10'd500};
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("b2b_first_done", vec_done, d0 + 1);
    chk("b2b_accept_gap", accept_cyc - last_pop_cyc, 1);
    wait_done(d0 + 2, 500, 1'b0);
    chk("b2b_rebs", reb_idx, 1);
    chk("b2b_rows", pop_idx, 1);
    chk("b2b_rlast_addr", rlast_addr, 500);

    // reset in the middle of a burst
    send_req(4, 100, 7);
    n = 0;
    while (reb_idx < 2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    #2 rst_n = 1'b0;
    #1;
    chk("mr_sram_req", sram_req, 0);
    chk("mr_reb", sram_reb, 0);
    chk("mr_rlast", sram_rlast, 0);
    chk("mr_addr", sram_addr, 0);
    chk("mr_rid", sram_rid, 0);
    chk("mr_dout_valid", dout_valid, 0);
    chk("mr_dout_data", dout_data == '0, 1);
    chk("mr_busy", busy, 0);
    chk("mr_req_ready", req_ready, 1);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    chk("mr_ready_after", req_ready, 1);
    d0 = vec_done;
    send_req(4, 100, 7);
    wait_done(d0 + 1, 500, 1'b0);
    chk("mr_rebs", reb_idx, 8);
    chk("mr_rows", pop_idx, 8);

    // random requests with random grant and consumer behaviour
    for (int i = 0; i < 25; i++) begin
      ret_lat = $urandom_range(1, 3);
      d0 = vec_done;
      send_req($urandom_range(0, 7), $urandom_range(0, 1023),
               $urandom_range(0, 31));
      wait_done(d0 + 1, 3000, 1'b1);
      chk("rnd_rebs", reb_idx, m_beats);
      chk("rnd_rows", pop_idx, m_beats);
    end

    sram_ack = 1'b0;
    dout_ready = 1'b0;
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
